seq_tx: RTL and testbench

//  Serial bit-sequence transmitter: accepts a parallel word over a valid/ready handshake
//  and drives it onto a 1-bit line, one bit per clock, then returns the line low.

---
 rtl/seq_tx_pkg.sv | 19 +
 rtl/seq_tx_shreg.sv | 51 +++++
 rtl/seq_tx.sv | 147 ++++++++++++++
 tb/tb_seq_tx.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_tx_pkg.sv
// Shared types and constants for the seq_tx serial transmitter.
package seq_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PRE   = 2'b01,
    SHIFT = 2'b10,
    GAP   = 2'b11
  } state_t;

  localparam logic [1:0]  PREAMBLE = 2'b11;
  localparam int unsigned PRE_LEN  = 2;

  // Counter width that stays legal (>= 1 bit) for counts of 0 or 1.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_tx_shreg.sv
// Loadable DATA_W shift register with bit counter; bit_out is the next bit to emit.
module seq_tx_shreg
  import seq_tx_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              shift,
  input  logic              msb_first,
  input  logic [DATA_W-1:0] data,
  output logic              bit_out,
  output logic              last
);

  localparam int unsigned CW = $clog2(DATA_W);

  logic [DATA_W-1:0] sh_q;
  logic [DATA_W-1:0] src;
  logic [DATA_W-1:0] drop;
  logic [CW-1:0]     cnt_q;

  // load bypass lets the first bit leave on the accepting edge itself
  always_comb begin
    src     = load ? data : sh_q;
    bit_out = msb_first ? src[DATA_W-1] : src[0];
    drop    = msb_first ? {src[DATA_W-2:0], 1'b0} : {1'b0, src[DATA_W-1:1]};
    last    = !load && (cnt_q == CW'(DATA_W - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else if (shift) begin
      sh_q <= drop;
      if (load) begin
        cnt_q <= CW'(1);
      end else if (last) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end else if (load) begin
      sh_q  <= data;
      cnt_q <= '0;
    end
  end

endmodule

// File: rtl/seq_tx.sv
// Serial bit-sequence transmitter: valid/ready word in, one bit per clock out.
// Optional "11" sync preamble before each frame when SEQ_TX_PREAMBLE_EN is defined.
module seq_tx
  import seq_tx_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned GAP_CYC   = 1,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out,
  output logic              out_en,
  output logic              busy,
  output logic              done
);

  localparam int unsigned    GW       = cnt_w(GAP_CYC);
  localparam logic [GW-1:0]  GAP_LAST = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  state_t        state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          out_q, out_d;
  logic          out_en_q, out_en_d;
  logic          done_q, done_d;
  logic          load, shift;
  logic          sh_bit, sh_last;
`ifdef SEQ_TX_PREAMBLE_EN
  logic          pre_q, pre_d;
`endif

  seq_tx_shreg #(
    .DATA_W (DATA_W)
  ) u_shreg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .shift     (shift),
    .msb_first (MSB_FIRST != 0),
    .data      (in_data),
    .bit_out   (sh_bit),
    .last      (sh_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gap_q    <= '0;
      out_q    <= 1'b0;
      out_en_q <= 1'b0;
      done_q   <= 1'b0;
`ifdef SEQ_TX_PREAMBLE_EN
      pre_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      out_q    <= out_d;
      out_en_q <= out_en_d;
      done_q   <= done_d;
`ifdef SEQ_TX_PREAMBLE_EN
      pre_q    <= pre_d;
`endif
    end
  end

  // Outputs are computed one edge ahead so out/out_en/done leave straight from flops.
  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    load     = 1'b0;
    shift    = 1'b0;
    out_d    = 1'b0;
    out_en_d = 1'b0;
    done_d   = 1'b0;
`ifdef SEQ_TX_PREAMBLE_EN
    pre_d    = pre_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          load     = 1'b1;
          out_en_d = 1'b1;
`ifdef SEQ_TX_PREAMBLE_EN
          state_d  = PRE;
          pre_d    = 1'b0;
          out_d    = PREAMBLE[1];
`else
          shift    = 1'b1;
          state_d  = SHIFT;
          out_d    = sh_bit;
`endif
        end
      end
      PRE: begin
`ifdef SEQ_TX_PREAMBLE_EN
        out_en_d = 1'b1;
        if (pre_q == 1'(PRE_LEN - 1)) begin
          shift   = 1'b1;
          state_d = SHIFT;
          out_d   = sh_bit;
          done_d  = sh_last;
        end else begin
          pre_d = pre_q + 1'b1;
          out_d = PREAMBLE[0];
        end
`else
        state_d = IDLE;
`endif
      end
      SHIFT: begin
        // done_q marks that the last data bit is on the line this cycle
        if (done_q) begin
          if (GAP_CYC > 0) begin
            state_d = GAP;
            gap_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          shift    = 1'b1;
          out_d    = sh_bit;
          out_en_d = 1'b1;
          done_d   = sh_last;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign out      = out_q;
  assign out_en   = out_en_q;
  assign done     = done_q;

endmodule

// File: tb/tb_seq_tx.sv
// Bench for seq_tx: two configurations driven side by side against a frame-position model.
module tb_seq_tx;

  localparam int W = 8;
`ifdef SEQ_TX_PREAMBLE_EN
  localparam int PRE = 2;
`else
  localparam int PRE = 0;
`endif

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic [1:0] rdy, o, en, bz, dn;

  int checks = 0;
  int errors = 0;

  seq_tx #(.DATA_W(8), .GAP_CYC(1), .MSB_FIRST(1)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy[0]), .out(o[0]), .out_en(en[0]), .busy(bz[0]), .done(dn[0])
  );

  seq_tx #(.DATA_W(8), .GAP_CYC(0), .MSB_FIRST(0)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy[1]), .out(o[1]), .out_en(en[1]), .busy(bz[1]), .done(dn[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int gapc(input int i);
    return (i == 0) ? 1 : 0;
  endfunction

  function automatic int msbc(input int i);
    return (i == 0) ? 1 : 0;
  endfunction

  // Model: pos = cycles since the accepting edge (0 = idle); frame is PRE + W + gap entries.
  int         pos[2];
  logic [7:0] wrd[2];
  int         n_acc[2], n_abort[2], n_done[2];

  function automatic int flen(input int i);
    return PRE + W + gapc(i);
  endfunction

  // {in_ready, busy, out, out_en, done}
  function automatic logic [4:0] expv(input int i);
    int   j;
    logic b;
    if (pos[i] == 0) return 5'b10000;
    j = pos[i] - 1;
    if (j < PRE) return 5'b01110;
    j = j - PRE;
    if (j < W) begin
      b = (msbc(i) != 0) ? wrd[i][W-1-j] : wrd[i][j];
      return {2'b01, b, 1'b1, (j == W - 1)};
    end
    return 5'b01000;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        if (pos[i] >= 1 && pos[i] <= PRE + W) n_abort[i]++;
        pos[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (pos[i] == 0) begin
          if (in_valid) begin
            pos[i] = 1;
            wrd[i] = in_data;
            n_acc[i]++;
          end
        end else if (pos[i] == flen(i)) begin
          pos[i] = 0;
        end else begin
          pos[i]++;
        end
      end
    end
  end

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, got, want);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = v[7-k];
    return r;
  endfunction

  // Per-cycle compare plus frame decoder (arrival order into raw, MSB = first data bit).
  logic [7:0] raw[2], last_raw[2];
  int         ecnt[2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [4:0] act;
      logic [7:0] dec;
      act = {rdy[i], bz[i], o[i], en[i], dn[i]};
      checks++;
      if (act !== expv(i)) begin
        errors++;
        $display("FAIL dut%0d_outputs {ready,busy,out,out_en,done} got %b want %b (pos %0d)",
                 i, act, expv(i), pos[i]);
      end
      if (!rst_n || !en[i]) begin
        ecnt[i] = 0;
      end else begin
        if (ecnt[i] >= PRE) raw[i] = {raw[i][6:0], o[i]};
        ecnt[i]++;
        if (dn[i]) begin
          n_done[i]++;
          last_raw[i] = raw[i];
          dec = (msbc(i) != 0) ? raw[i] : rev8(raw[i]);
          checks++;
          if (dec !== wrd[i]) begin
            errors++;
            $display("FAIL dut%0d_word got %h want %h", i, dec, wrd[i]);
          end
        end
      end
    end
  end

  // One-cycle valid pulse while both units idle; checks return-to-ready latency and bit order.
  task automatic send_one(input logic [7:0] w, input logic [7:0] raw0, input logic [7:0] raw1);
    int lat0, lat1;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = w;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat0 = -1;
    lat1 = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (lat0 < 0 && rdy[0]) lat0 = c;
      if (lat1 < 0 && rdy[1]) lat1 = c;
    end
    chk("ready_latency_u0", lat0, 10 + PRE);
    chk("ready_latency_u1", lat1, 9 + PRE);
    chk("raw_bits_u0", int'(last_raw[0]), int'(raw0));
    chk("raw_bits_u1", int'(last_raw[1]), int'(raw1));
  endtask

  initial begin
    int lat, nd0, nd1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    #1 rst_n = 1'b0;

    // Reset state, held and just after release
    repeat (3) @(posedge clk);
    #1;
    chk("reset_u0", int'({rdy[0], bz[0], o[0], en[0], dn[0]}), 5'b10000);
    chk("reset_u1", int'({rdy[1], bz[1], o[1], en[1], dn[1]}), 5'b10000);
    @(posedge clk); #2 rst_n = 1'b1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_reset_u0", int'({rdy[0], bz[0], o[0], en[0], dn[0]}), 5'b10000);

    // Bit order: 01 arrives as 0000_0001 MSB-first, 1000_0000 LSB-first
    send_one(8'h01, 8'h01, 8'h80);
    send_one(8'hA5, 8'hA5, 8'hA5);

    // Held valid: second word waits for the next IDLE
    nd0 = n_done[0];
    nd1 = n_done[1];
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    @(posedge clk); #1;
    in_data = 8'h00;
    lat = -1;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      @(negedge clk);
      if (rdy[0]) lat = c;
    end
    chk("held_valid_reaccept_u0", lat, 10 + PRE);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (40) @(negedge clk);
    chk("held_valid_last_u0", int'(last_raw[0]), 8'h00);
    chk("held_valid_frames_u0", n_done[0] - nd0, 2);
    chk("held_valid_frames_u1", n_done[1] - nd1, 2);

    // Reset during bit 4 of F0: immediate idle outputs, no done
    nd0 = n_done[0];
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = 8'hF0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4 + PRE) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_u0", int'({bz[0], o[0], en[0], dn[0]}), 4'b0000);
    chk("abort_u1", int'({bz[1], o[1], en[1], dn[1]}), 4'b0000);
    @(posedge clk);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    chk("abort_no_done_u0", n_done[0], nd0);
    send_one(8'h0F, 8'h0F, 8'hF0);

    // Random traffic with occasional asynchronous resets
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      in_valid = ($urandom_range(0, 2) != 0);
      in_data  = 8'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        #1 rst_n = 1'b0;
        @(posedge clk); #2 rst_n = 1'b1;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (40) @(negedge clk);
    chk("frame_count_u0", n_done[0], n_acc[0] - n_abort[0]);
    chk("frame_count_u1", n_done[1], n_acc[1] - n_abort[1]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
